// File: rtl/muxn_pipe.sv
// N-input data multiplexer followed by a stallable, flushable register pipeline.
// Out-of-range selects substitute OOR_VALUE, flag the beat and bump a saturating error counter.
module muxn_pipe #(
    parameter int                 NB_DATA    = 32,
    parameter int                 N_INPUTS   = 4,
    parameter int                 NB_SEL     = $clog2(N_INPUTS),
    parameter int                 PIPE_DEPTH = 1,
    parameter logic [NB_DATA-1:0] OOR_VALUE  = '0
) (
    input  logic                         i_clk,
    input  logic                         i_rst_n,
    input  logic [N_INPUTS*NB_DATA-1:0]  i_DATA,
    input  logic [NB_SEL-1:0]            i_SEL,
    input  logic                         i_VALID,
    input  logic                         i_STALL,
    input  logic                         i_FLUSH,
    output logic [NB_DATA-1:0]           o_OUT,
    output logic                         o_VALID,
    output logic                         o_SEL_ERR,
    output logic [7:0]                   o_ERR_CNT
);

    // One extra bit so N_INPUTS == 2**NB_SEL still fits; the compare is then never true.
    localparam logic [NB_SEL:0] N_LIMIT = (NB_SEL + 1)'(N_INPUTS);

    logic [NB_DATA-1:0]                   sel_data;
    logic                                 sel_oor;
    logic [PIPE_DEPTH-1:0][NB_DATA-1:0]   data_q, data_d;
    logic [PIPE_DEPTH-1:0]                valid_q, valid_d;
    logic [PIPE_DEPTH-1:0]                err_q, err_d;
    logic [7:0]                           err_cnt_q, err_cnt_d;

    always_comb begin
        sel_oor  = ({1'b0, i_SEL} >= N_LIMIT);
        sel_data = OOR_VALUE;
        for (int unsigned k = 0; k < N_INPUTS; k++) begin
            if (i_SEL == NB_SEL'(k)) begin
                sel_data = i_DATA[k*NB_DATA +: NB_DATA];
            end
        end
    end

    always_comb begin
        data_d    = data_q;
        valid_d   = valid_q;
        err_d     = err_q;
        err_cnt_d = err_cnt_q;
        if (i_FLUSH) begin
            valid_d = '0;
            err_d   = '0;
        end else if (!i_STALL) begin
            data_d[0]  = sel_data;
            valid_d[0] = i_VALID;
            err_d[0]   = i_VALID && sel_oor;
            for (int unsigned s = 1; s < PIPE_DEPTH; s++) begin
                data_d[s]  = data_q[s-1];
                valid_d[s] = valid_q[s-1];
                err_d[s]   = err_q[s-1];
            end
            if (i_VALID && sel_oor && (err_cnt_q != 8'hFF)) begin
                err_cnt_d = err_cnt_q + 8'd1;
            end
        end
    end

    always_ff @(posedge i_clk) begin
        if (!i_rst_n) begin
            data_q    <= '0;
            valid_q   <= '0;
            err_q     <= '0;
            err_cnt_q <= '0;
        end else begin
            data_q    <= data_d;
            valid_q   <= valid_d;
            err_q     <= err_d;
            err_cnt_q <= err_cnt_d;
        end
    end

    assign o_OUT     = data_q[PIPE_DEPTH-1];
    assign o_VALID   = valid_q[PIPE_DEPTH-1];
    assign o_SEL_ERR = err_q[PIPE_DEPTH-1];
    assign o_ERR_CNT = err_cnt_q;

endmodule

// File: tb/tb_muxn_pipe.sv
// Bench for muxn_pipe: eleven parameter sets share one stimulus stream; each is checked
// against a queue-based reference model, plus directed tables and sequences.
module tb_muxn_pipe;

    localparam int NCFG = 11;
    localparam int              CFG_N   [NCFG] = '{4, 5, 5, 2, 2, 3, 3, 8, 8, 16, 16};
    localparam int              CFG_D   [NCFG] = '{1, 2, 3, 1, 4, 1, 4, 1, 4, 1, 4};
    localparam logic [15:0]     CFG_OOR [NCFG] = '{16'h0000, 16'hDEAD, 16'hDEAD, 16'hBEEF,
                                                   16'hBEEF, 16'hBEEF, 16'hBEEF, 16'h0000,
                                                   16'h0000, 16'h0000, 16'h0000};

    logic         clk;
    logic         rst_n;
    logic [255:0] data_all;
    logic [3:0]   sel_raw;
    logic         valid, stall, flush;

    logic [15:0]  dut_out [NCFG];
    logic         dut_vld [NCFG];
    logic         dut_err [NCFG];
    logic [7:0]   dut_cnt [NCFG];

    int n_cmp = 0;
    int n_bad = 0;

    for (genvar g = 0; g < NCFG; g++) begin : g_cfg
        localparam int N  = CFG_N[g];
        localparam int SW = $clog2(N);
        muxn_pipe #(
            .NB_DATA    (16),
            .N_INPUTS   (N),
            .NB_SEL     (SW),
            .PIPE_DEPTH (CFG_D[g]),
            .OOR_VALUE  (CFG_OOR[g])
        ) u_dut (
            .i_clk     (clk),
            .i_rst_n   (rst_n),
            .i_DATA    (data_all[N*16-1:0]),
            .i_SEL     (sel_raw[SW-1:0]),
            .i_VALID   (valid),
            .i_STALL   (stall),
            .i_FLUSH   (flush),
            .o_OUT     (dut_out[g]),
            .o_VALID   (dut_vld[g]),
            .o_SEL_ERR (dut_err[g]),
            .o_ERR_CNT (dut_cnt[g])
        );
    end

    initial clk = 1'b0;
    always #5 clk = ~clk;

    typedef struct {
        logic [15:0] data;
        bit          valid;
        bit          err;
    } beat_t;

    beat_t mq    [NCFG][$];
    int    m_cnt [NCFG];

    function automatic void chk(string nm, int c, logic [15:0] act, logic [15:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_bad++;
            $display("FAIL %s cfg%0d: got %h, expected %h", nm, c, act, exp);
        end
    endfunction

    function automatic beat_t new_beat(int c);
        beat_t b;
        int    w = 0;
        int    s;
        while ((1 << w) < CFG_N[c]) w++;
        s = int'(sel_raw) % (1 << w);
        b.data  = (s < CFG_N[c]) ? data_all[s*16 +: 16] : CFG_OOR[c];
        b.valid = valid;
        b.err   = valid && (s >= CFG_N[c]);
        return b;
    endfunction

    function automatic void model_edge();
        beat_t b;
        for (int c = 0; c < NCFG; c++) begin
            if (!rst_n) begin
                mq[c].delete();
                for (int i = 0; i < CFG_D[c]; i++) mq[c].push_back('{16'h0000, 1'b0, 1'b0});
                m_cnt[c] = 0;
            end else if (flush) begin
                for (int i = 0; i < mq[c].size(); i++) begin
                    mq[c][i].valid = 1'b0;
                    mq[c][i].err   = 1'b0;
                end
            end else if (!stall) begin
                b = new_beat(c);
                mq[c].push_front(b);
                void'(mq[c].pop_back());
                if (b.err && m_cnt[c] < 255) m_cnt[c]++;
            end
        end
    endfunction

    task automatic step();
        beat_t b;
        model_edge();
        @(posedge clk);
        #1;
        for (int c = 0; c < NCFG; c++) begin
            b = mq[c][mq[c].size()-1];
            chk("model_out",   c, dut_out[c],      b.data);
            chk("model_valid", c, 16'(dut_vld[c]), 16'(b.valid));
            chk("model_err",   c, 16'(dut_err[c]), 16'(b.err));
            chk("model_cnt",   c, 16'(dut_cnt[c]), 16'(m_cnt[c]));
        end
    endtask

    task automatic drive(bit r, bit v, bit s, bit f, logic [3:0] sel);
        rst_n   = r;
        valid   = v;
        stall   = s;
        flush   = f;
        sel_raw = sel;
    endtask

    task automatic set_channels();
        for (int k = 0; k < 16; k++) data_all[k*16 +: 16] = 16'((k + 1) * 'h11);
    endtask

    typedef struct {
        bit          rst_n, valid, stall, flush;
        logic [3:0]  sel;
        logic [15:0] out;
        bit          vld, err;
        logic [7:0]  cnt;
    } vec_t;

    vec_t tbl [10];

    initial begin
        tbl = '{
            '{1'b0, 1'b0, 1'b0, 1'b0, 4'd0, 16'h0000, 1'b0, 1'b0, 8'd0},
            '{1'b1, 1'b1, 1'b0, 1'b0, 4'd2, 16'h0033, 1'b1, 1'b0, 8'd0},
            '{1'b1, 1'b1, 1'b0, 1'b0, 4'd0, 16'h0011, 1'b1, 1'b0, 8'd0},
            '{1'b1, 1'b0, 1'b0, 1'b0, 4'd3, 16'h0044, 1'b0, 1'b0, 8'd0},
            '{1'b1, 1'b1, 1'b0, 1'b0, 4'd1, 16'h0022, 1'b1, 1'b0, 8'd0},
            '{1'b1, 1'b1, 1'b1, 1'b0, 4'd2, 16'h0022, 1'b1, 1'b0, 8'd0},
            '{1'b1, 1'b1, 1'b0, 1'b1, 4'd3, 16'h0022, 1'b0, 1'b0, 8'd0},
            '{1'b1, 1'b1, 1'b0, 1'b0, 4'd6, 16'h0033, 1'b1, 1'b0, 8'd0},
            '{1'b1, 1'b1, 1'b1, 1'b1, 4'd1, 16'h0033, 1'b0, 1'b0, 8'd0},
            '{1'b0, 1'b1, 1'b0, 1'b0, 4'd1, 16'h0000, 1'b0, 1'b0, 8'd0}
        };
        set_channels();
        drive(1'b0, 1'b0, 1'b0, 1'b0, 4'd0);
        #2;

        // Basic select/latency table on the 4-input, depth-1 instance.
        foreach (tbl[i]) begin
            drive(tbl[i].rst_n, tbl[i].valid, tbl[i].stall, tbl[i].flush, tbl[i].sel);
            step();
            chk($sformatf("tbl%0d_out", i),   0, dut_out[0],      tbl[i].out);
            chk($sformatf("tbl%0d_valid", i), 0, 16'(dut_vld[0]), 16'(tbl[i].vld));
            chk($sformatf("tbl%0d_err", i),   0, 16'(dut_err[0]), 16'(tbl[i].err));
            chk($sformatf("tbl%0d_cnt", i),   0, 16'(dut_cnt[0]), 16'(tbl[i].cnt));
        end

        // Out-of-range beat then saturation on the 5-input, depth-2 instance.
        drive(1'b0, 1'b0, 1'b0, 1'b0, 4'd0); step();
        drive(1'b1, 1'b1, 1'b0, 1'b0, 4'd7); step();
        drive(1'b1, 1'b0, 1'b0, 1'b0, 4'd0); step();
        chk("oor_out",   1, dut_out[1],      16'hDEAD);
        chk("oor_valid", 1, 16'(dut_vld[1]), 16'd1);
        chk("oor_err",   1, 16'(dut_err[1]), 16'd1);
        chk("oor_cnt",   1, 16'(dut_cnt[1]), 16'd1);
        drive(1'b1, 1'b1, 1'b0, 1'b0, 4'd7);
        repeat (300) step();
        chk("sat_cnt", 1, 16'(dut_cnt[1]), 16'd255);
        step();
        chk("sat_hold", 1, 16'(dut_cnt[1]), 16'd255);

        // Stall with beat D dropped, depth-3 instance.
        drive(1'b0, 1'b0, 1'b0, 1'b0, 4'd0); step();
        for (int i = 0; i < 3; i++) begin
            drive(1'b1, 1'b1, 1'b0, 1'b0, 4'(i)); step();
        end
        chk("stall_pre", 2, dut_out[2], 16'h0011);
        drive(1'b1, 1'b1, 1'b1, 1'b0, 4'd3);
        for (int i = 0; i < 4; i++) begin
            step();
            chk($sformatf("stall_hold%0d_out", i), 2, dut_out[2],      16'h0011);
            chk($sformatf("stall_hold%0d_vld", i), 2, 16'(dut_vld[2]), 16'd1);
        end
        drive(1'b1, 1'b1, 1'b0, 1'b0, 4'd4); step();
        chk("stall_rel_b", 2, dut_out[2], 16'h0022);
        drive(1'b1, 1'b0, 1'b0, 1'b0, 4'd0); step();
        chk("stall_rel_c", 2, dut_out[2], 16'h0033);
        step();
        chk("stall_rel_e",   2, dut_out[2],      16'h0055);
        chk("stall_rel_vld", 2, 16'(dut_vld[2]), 16'd1);

        // Flush together with stall while three beats are in flight.
        drive(1'b0, 1'b0, 1'b0, 1'b0, 4'd0); step();
        drive(1'b1, 1'b1, 1'b0, 1'b0, 4'd7); step();
        drive(1'b1, 1'b1, 1'b0, 1'b0, 4'd1); step();
        drive(1'b1, 1'b1, 1'b0, 1'b0, 4'd2); step();
        chk("fl_pre_err", 2, 16'(dut_err[2]), 16'd1);
        drive(1'b1, 1'b1, 1'b1, 1'b1, 4'd7); step();
        chk("fl_out",   2, dut_out[2],      16'hDEAD);
        chk("fl_valid", 2, 16'(dut_vld[2]), 16'd0);
        chk("fl_err",   2, 16'(dut_err[2]), 16'd0);
        chk("fl_cnt",   2, 16'(dut_cnt[2]), 16'd1);
        drive(1'b1, 1'b0, 1'b0, 1'b0, 4'd0); step();
        chk("fl_after_out",   2, dut_out[2],      16'h0022);
        chk("fl_after_valid", 2, 16'(dut_vld[2]), 16'd0);

        // Reset mid-stream, then a beat in the first post-reset cycle.
        drive(1'b0, 1'b0, 1'b0, 1'b0, 4'd0); step();
        drive(1'b1, 1'b1, 1'b0, 1'b0, 4'd7);
        repeat (3) step();
        chk("rst_pre_cnt", 2, 16'(dut_cnt[2]), 16'd3);
        drive(1'b0, 1'b1, 1'b0, 1'b0, 4'd7); step();
        chk("rst_out",   2, dut_out[2],      16'h0000);
        chk("rst_valid", 2, 16'(dut_vld[2]), 16'd0);
        chk("rst_err",   2, 16'(dut_err[2]), 16'd0);
        chk("rst_cnt",   2, 16'(dut_cnt[2]), 16'd0);
        drive(1'b1, 1'b1, 1'b0, 1'b0, 4'd1); step();
        chk("post1_valid", 2, 16'(dut_vld[2]), 16'd0);
        drive(1'b1, 1'b0, 1'b0, 1'b0, 4'd0); step();
        chk("post2_valid", 2, 16'(dut_vld[2]), 16'd0);
        step();
        chk("post3_out",   2, dut_out[2],      16'h0022);
        chk("post3_valid", 2, 16'(dut_vld[2]), 16'd1);

        // Randomised run against the model on every instance.
        drive(1'b0, 1'b0, 1'b0, 1'b0, 4'd0); step();
        for (int cyc = 0; cyc < 10000; cyc++) begin
            for (int k = 0; k < 16; k++) data_all[k*16 +: 16] = 16'($urandom);
            drive($urandom_range(0, 99) != 0, 1'($urandom), $urandom_range(0, 4) == 0,
                  $urandom_range(0, 15) == 0, 4'($urandom));
            step();
            if (n_bad > 50) break;
        end

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule

// File: doc/muxn_pipe.md
MUXN_PIPE -- requirements
Module: muxn_pipe

Interface
- REQ-001 The block SHALL have parameter NB_DATA, default 32, giving the width of each data channel.
- REQ-002 The block SHALL have parameter N_INPUTS, default 4, giving the number of input channels; legal range is 2..16.
- REQ-003 The block SHALL have parameter NB_SEL, default $clog2(N_INPUTS), giving the select width.
- REQ-004 The block SHALL have parameter PIPE_DEPTH, default 1, giving the number of register stages; legal range is 1..4.
- REQ-005 The block SHALL have parameter OOR_VALUE, default 0, NB_DATA wide, giving the data substituted on an out-of-range select.
- REQ-006 Port i_clk, input, 1 bit: the single clock; all state updates on its rising edge.
- REQ-007 Port i_rst_n, input, 1 bit: the reset, synchronous and active-low.
- REQ-008 Port i_DATA, input, N_INPUTS*NB_DATA bits: packed channels; channel k occupies bits [k*NB_DATA +: NB_DATA].
- REQ-009 Port i_SEL, input, NB_SEL bits: channel select.
- REQ-010 Port i_VALID, input, 1 bit: the current i_DATA/i_SEL beat is meaningful.
- REQ-011 Port i_STALL, input, 1 bit: freeze all pipeline stages.
- REQ-012 Port i_FLUSH, input, 1 bit: invalidate all pipeline stages.
- REQ-013 Port o_OUT, output, NB_DATA bits: selected data from the last stage.
- REQ-014 Port o_VALID, output, 1 bit: o_OUT is valid.
- REQ-015 Port o_SEL_ERR, output, 1 bit: the beat in the last stage had i_SEL >= N_INPUTS.
- REQ-016 Port o_ERR_CNT, output, 8 bits: saturating count of accepted out-of-range beats.

Function
- REQ-017 Stage 0 SHALL capture the following on each edge where reset is inactive, i_FLUSH=0 and i_STALL=0:
  - data = channel i_SEL when i_SEL < N_INPUTS, otherwise OOR_VALUE;
  - valid = i_VALID;
  - err = i_VALID AND (i_SEL >= N_INPUTS).
- REQ-018 Stage s (1 ≤ s < PIPE_DEPTH) SHALL capture stage s-1 under the same enable condition.
- REQ-019 o_OUT, o_VALID and o_SEL_ERR SHALL be driven directly from the last stage registers; latency from input to output is exactly PIPE_DEPTH cycles.
- REQ-020 When i_STALL=1 and i_FLUSH=0, every stage SHALL hold its data, valid and err; the incoming beat is dropped, and the source is responsible for holding it.
- REQ-021 When i_FLUSH=1, every stage SHALL set valid=0 and err=0 and keep its data; i_FLUSH takes priority over i_STALL.
- REQ-022 o_ERR_CNT SHALL increment by 1 on each edge where the stage-0 capture condition holds, i_VALID=1 and i_SEL >= N_INPUTS; i_FLUSH does not clear it.
- REQ-023 o_ERR_CNT SHALL saturate at 255 and never wrap.
- REQ-024 When i_VALID=0, stage-0 data SHALL still be captured per REQ-017, and o_ERR_CNT SHALL not change.
- REQ-025 When N_INPUTS is a power of two, no out-of-range select exists; o_SEL_ERR SHALL then be constant 0 and o_ERR_CNT SHALL stay 0.
- REQ-026 The select decode SHALL be fully specified for every i_SEL value, so the block infers no latches.

Reset
- REQ-027 On an edge with i_rst_n=0, every stage SHALL clear data, valid and err to 0, and o_ERR_CNT SHALL clear to 0; reset overrides i_FLUSH and i_STALL.
- REQ-028 While in reset, outputs SHALL read o_OUT=0, o_VALID=0, o_SEL_ERR=0, o_ERR_CNT=0.
- REQ-029 Reset asserted mid-stream SHALL discard all in-flight beats.
- REQ-030 On the first edge with i_rst_n=1, the block SHALL capture normally.

Verification
- REQ-031 Basic select and latency, N_INPUTS=4, PIPE_DEPTH=1: channels = 0x11, 0x22, 0x33, 0x44; i_SEL = 2 with i_VALID=1 -> one cycle later o_OUT=0x33, o_VALID=1, o_SEL_ERR=0.
- REQ-032 Out-of-range and saturation, N_INPUTS=5, OOR_VALUE=0xDEAD, PIPE_DEPTH=2: i_SEL=7 with i_VALID=1 -> two cycles later o_OUT=0xDEAD, o_SEL_ERR=1, o_ERR_CNT=1. Continuing for 300 valid cycles -> o_ERR_CNT holds at 255.
- REQ-033 Stall, PIPE_DEPTH=3: stream beats A, B, C, then assert i_STALL for 4 cycles while driving D -> outputs frozen for those 4 cycles; D never appears; after release the next input beat follows in order.
- REQ-034 Flush during stall, PIPE_DEPTH=3: assert i_FLUSH and i_STALL together with 3 valid beats in flight -> o_VALID=0 next cycle; o_OUT unchanged; o_ERR_CNT unchanged.
- REQ-035 Reset mid-stream: with o_ERR_CNT=3 and valid beats in flight, drive i_rst_n=0 for 1 cycle -> next edge all outputs 0; a beat presented in the first post-reset cycle appears after PIPE_DEPTH cycles.
- REQ-036 Randomised check: random i_SEL, i_VALID, i_STALL and i_FLUSH for 10k cycles, N_INPUTS in {2, 3, 8, 16} and PIPE_DEPTH in {1, 4} -> outputs match a cycle-accurate reference model exactly.
